// File: rtl/byte_serial_adder_seq.sv
// Byte-serial sequencer for an external 8-bit adder: slices a wide
// add/sub request LSB first and returns the reassembled result with flags.
module byte_serial_adder_seq #(
    parameter int NBYTES = 4,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_sum,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_carry,
    output logic         out_ovf,
    output logic         out_zero
);

    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_nxt;
    logic          carry_q;
    logic [IW-1:0] idx;
    logic          last;

    assign last      = (idx == IW'(NBYTES - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // The adder only sees live operands while a slice is in flight.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[8*idx +: 8];
            add_b   = b_q[8*idx +: 8];
            add_cin = carry_q;
        end
    end

    always_comb begin
        acc_nxt = acc_q;
        acc_nxt[8*idx +: 8] = add_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            idx       <= '0;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_sub ? ~in_b : in_b;
                        carry_q <= in_sub;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= acc_nxt;
                    carry_q <= add_cout;
                    idx     <= idx + IW'(1);
                    if (last) begin
                        state     <= DONE;
                        out_sum   <= acc_nxt;
                        out_carry <= add_cout;
                        out_ovf   <= (a_q[W-1] == b_q[W-1]) &&
                                     (acc_nxt[W-1] != a_q[W-1]);
                        out_zero  <= (acc_nxt == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_adder_seq.sv
// Bench for byte_serial_adder_seq: directed corner cases plus randomized
// operations checked against a plain-arithmetic reference.
module tb_byte_serial_adder_seq;

    localparam int NBYTES = 4;
    localparam int W = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_ovf;
    logic         out_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // The 8-bit adder stage the sequencer drives.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    byte_serial_adder_seq #(.NBYTES(NBYTES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_carry(out_carry),
        .out_ovf  (out_ovf),
        .out_zero (out_zero)
    );

    // Reference: {sum, carry, ovf, zero} from integer arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic sub);
        logic [W-1:0] s;
        logic         c;
        logic         o;
        longint       r;
        if (sub) begin
            s = a - b;
            c = (a >= b);
            r = longint'($signed(a)) - longint'($signed(b));
        end else begin
            {c, s} = {1'b0, a} + {1'b0, b};
            r = longint'($signed(a)) + longint'($signed(b));
        end
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {s, c, o, (s == '0)};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, output bit ok);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = in_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = $urandom;
        in_b = $urandom;
        in_sub = 1'($urandom);
    endtask

    // Cycles after the accepting edge until out_valid; add_cin per slice.
    task automatic wait_done(output int lat, output logic [NBYTES-1:0] cins);
        lat = 0;
        cins = '0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            if (lat < NBYTES) cins[lat] = add_cin;
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_sub = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero,
             add_a, add_b, add_cin} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000,
             16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b sum=%h a=%h b=%h cin=%b",
                     in_ready, out_valid, out_sum, add_a, add_b, add_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL post_reset: rdy=%b vld=%b required 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_ripple_latency();
        int lat;
        logic [NBYTES-1:0] cins;
        bit ok;
        out_ready = 1'b1;
        start(32'h0000_00FF, 32'h0000_0001, 1'b0, ok);
        if (!ok) return;
        wait_done(lat, cins);
        checks++;
        if (lat !== NBYTES) begin
            errors++;
            $display("FAIL latency: got %0d required %0d", lat, NBYTES);
        end
        checks++;
        if (cins !== 4'b0010) begin
            errors++;
            $display("FAIL cin_seq: got %b required 0010 (msb=last)", cins);
        end
        checks++;
        if ({out_sum, out_carry, out_ovf, out_zero} !== {32'h100, 3'b000}) begin
            errors++;
            $display("FAIL ripple_result: sum=%h c=%b o=%b z=%b", out_sum,
                     out_carry, out_ovf, out_zero);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL ripple_release: vld=%b rdy=%b required 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                               32'd5, 32'd5, 32'h0000_00FF};
        logic [W-1:0] tb[6] = '{32'd1, 32'd1, 32'd1, 32'd7, 32'd5, 32'd1};
        logic         ts[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [W+2:0] te[6] = '{{32'h0, 3'b101}, {32'h8000_0000, 3'b010},
                               {32'h7FFF_FFFF, 3'b110},
                               {32'hFFFF_FFFE, 3'b000}, {32'h0, 3'b101},
                               {32'h100, 3'b000}};
        int lat;
        logic [NBYTES-1:0] cins;
        bit ok;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start(ta[i], tb[i], ts[i], ok);
            if (!ok) return;
            wait_done(lat, cins);
            checks++;
            if ({out_valid, out_sum, out_carry, out_ovf, out_zero} !==
                {1'b1, te[i]}) begin
                errors++;
                $display("FAIL directed_%0d: vld=%b sum=%h cvz=%b%b%b req %h",
                         i, out_valid, out_sum, out_carry, out_ovf, out_zero,
                         te[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [W+2:0] exp;
        int lat;
        logic [NBYTES-1:0] cins;
        bit ok;
        out_ready = 1'b0;
        exp = model(32'h1234_5678, 32'h1111_1111, 1'b0);
        start(32'h1234_5678, 32'h1111_1111, 1'b0, ok);
        if (!ok) return;
        wait_done(lat, cins);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_a = $urandom;
            in_b = $urandom;
            in_sub = ~in_sub;
            checks++;
            if ({out_valid, in_ready, out_sum, out_carry, out_ovf, out_zero}
                !== {2'b10, exp}) begin
                errors++;
                $display("FAIL bp_hold_%0d: vld=%b rdy=%b sum=%h req %h", i,
                         out_valid, in_ready, out_sum, exp[W+2:3]);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: vld=%b rdy=%b required 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [W+2:0] exp;
        int lat;
        int bad = 0;
        logic [NBYTES-1:0] cins;
        bit ok;
        out_ready = 1'b1;
        start(32'h1122_3344, 32'h0102_0304, 1'b0, ok);
        if (!ok) return;
        repeat (3) @(negedge clk);
        checks++;
        if ({add_a, add_b} !== 16'h2202) begin
            errors++;
            $display("FAIL mid_slice2: a=%h b=%h required 22 02", add_a, add_b);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero,
             add_a, add_b, add_cin} !== {1'b1, 1'b0, {W{1'b0}}, 3'b000,
             16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: rdy=%b vld=%b a=%h b=%h cin=%b",
                     in_ready, out_valid, add_a, add_b, add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_no_result: out_valid high %0d cycles, req 0", bad);
        end
        exp = model(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        start(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, ok);
        if (!ok) return;
        wait_done(lat, cins);
        checks++;
        if ({out_valid, out_sum, out_carry, out_ovf, out_zero} !==
            {1'b1, exp}) begin
            errors++;
            $display("FAIL mid_recover: vld=%b sum=%h req %h", out_valid,
                     out_sum, exp[W+2:3]);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W+2:0] q[$];
        logic [W+2:0] exp;
        int cyc[5];
        int issued = 0;
        int done = 0;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic s;
        out_ready = 1'b1;
        for (int t = 0; t < 200 && done < 5; t++) begin
            @(negedge clk);
            if (out_valid) begin
                exp = q.pop_front();
                cyc[done] = t;
                checks++;
                if ({out_sum, out_carry, out_ovf, out_zero} !== exp) begin
                    errors++;
                    $display("FAIL b2b_%0d: sum=%h cvz=%b%b%b req %h", done,
                             out_sum, out_carry, out_ovf, out_zero, exp);
                end
                done++;
            end
            if (in_ready) begin
                if (issued < 5) begin
                    a = pick();
                    b = pick();
                    s = 1'($urandom);
                    in_a = a;
                    in_b = b;
                    in_sub = s;
                    in_valid = 1'b1;
                    q.push_back(model(a, b, s));
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                in_a = $urandom;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (done != 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d results required 5", done);
        end
        for (int i = 1; i < done; i++) begin
            checks++;
            if (cyc[i] - cyc[i-1] != NBYTES + 2) begin
                errors++;
                $display("FAIL b2b_period_%0d: got %0d required %0d", i,
                         cyc[i] - cyc[i-1], NBYTES + 2);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic s;
        logic [W+2:0] exp;
        int lat;
        logic [NBYTES-1:0] cins;
        bit ok;
        for (int i = 0; i < 30; i++) begin
            a = pick();
            b = pick();
            s = 1'($urandom);
            exp = model(a, b, s);
            out_ready = 1'b0;
            start(a, b, s, ok);
            if (!ok) return;
            wait_done(lat, cins);
            checks++;
            if ({out_valid, out_sum, out_carry, out_ovf, out_zero} !==
                {1'b1, exp} || lat != NBYTES) begin
                errors++;
                $display("FAIL rand_%0d: %h %s %h sum=%h cvz=%b%b%b lat=%0d req %h",
                         i, a, s ? "-" : "+", b, out_sum, out_carry, out_ovf,
                         out_zero, lat, exp);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_ripple_latency();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
